// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage types and constants
package cpu_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef enum logic [1:0] {FETCH, WAIT, HOLD, HALT} fetch_state_t;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction memory request/response bus
interface instr_fetch_unit_if;
  import cpu_pkg::*;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  modport master(output imem_req, imem_addr, input imem_ready, imem_rvalid, imem_rdata);
  modport slave(input imem_req, imem_addr, output imem_ready, imem_rvalid, imem_rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner, single-outstanding word fetch, holds instruction for decode
module instr_fetch_unit import cpu_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [XLEN-1:0] NOP_INST = cpu_pkg::NOP_INST
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  imem,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic                inst_valid,
  output logic [XLEN-1:0]     inst,
  output logic [XLEN-1:0]     pc,
  output logic [XLEN-1:0]     pc_plus4,
  output logic                fetch_fault
);
  fetch_state_t state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, inst_q, inst_d, pc_q, pc_d;
  logic inst_valid_q, inst_valid_d, drop_q, drop_d, fault_q, fault_d;
  logic live, misaligned;
  assign live = state_q != HALT;
  assign misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
  // state register; reset abandons any in-flight request
  always_ff @(posedge clk)
    state_q <= !rst ? FETCH : state_d;
  // next state: misaligned redirect halts, otherwise redirect beats normal flow
  always_comb begin
    state_d = state_q;
    if (live && misaligned) state_d = HALT;
    else case (state_q)
      FETCH:   state_d = imem.imem_ready ? WAIT : FETCH;
      WAIT:    state_d = !imem.imem_rvalid ? WAIT : (drop_q || redirect_valid) ? FETCH : HOLD;
      HOLD:    state_d = (redirect_valid || !stall) ? FETCH : HOLD;
      default: state_d = HALT;
    endcase
  end
  // datapath next values; drop marks a response already in flight that must be discarded
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    inst_d       = inst_q;
    pc_d         = pc_q;
    inst_valid_d = inst_valid_q;
    drop_d       = drop_q;
    fault_d      = fault_q;
    if (live && misaligned) begin
      fault_d      = 1'b1;
      inst_valid_d = 1'b0;
      inst_d       = NOP_INST;
    end else if (live && redirect_valid) begin
      fetch_pc_d   = redirect_pc;
      drop_d       = (state_q == FETCH && imem.imem_ready) || (state_q == WAIT && !imem.imem_rvalid);
      inst_valid_d = 1'b0;
      inst_d       = NOP_INST;
    end else if (state_q == WAIT && imem.imem_rvalid) begin
      drop_d       = 1'b0;
      inst_d       = drop_q ? inst_q : imem.imem_rdata;
      pc_d         = drop_q ? pc_q : fetch_pc_q;
      inst_valid_d = !drop_q;
    end else if (state_q == HOLD && !stall) begin
      fetch_pc_d   = fetch_pc_q + 32'd4;
      inst_valid_d = 1'b0;
      inst_d       = NOP_INST;
    end
  end
  // datapath registers
  always_ff @(posedge clk)
    if (!rst) begin
      fetch_pc_q   <= RESET_PC;
      inst_q       <= NOP_INST;
      pc_q         <= RESET_PC;
      inst_valid_q <= 1'b0;
      drop_q       <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      inst_q       <= inst_d;
      pc_q         <= pc_d;
      inst_valid_q <= inst_valid_d;
      drop_q       <= drop_d;
      fault_q      <= fault_d;
    end
  // outputs: request only in FETCH and never while reset is asserted
  always_comb begin
    imem.imem_req  = rst && state_q == FETCH;
    imem.imem_addr = fetch_pc_q;
    inst_valid     = inst_valid_q;
    inst           = inst_q;
    pc             = pc_q;
    pc_plus4       = pc_q + 32'd4;
    fetch_fault    = fault_q;
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed table and sequence checks for the fetch unit
module tb_instr_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0, rst = 1'b0, stall = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic inst_valid, fetch_fault, inst_valid2, fetch_fault2;
  logic [31:0] inst, pc, pc_plus4, inst2, pc2, pc_plus42;
  int checks = 0, failures = 0;
  instr_fetch_unit_if bus();
  instr_fetch_unit_if bus2();
  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .imem(bus), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst(inst), .pc(pc),
    .pc_plus4(pc_plus4), .fetch_fault(fetch_fault)
  );
  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .imem(bus2), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid2), .inst(inst2), .pc(pc2),
    .pc_plus4(pc_plus42), .fetch_fault(fetch_fault2)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic ready, rvalid;
    logic [31:0] rdata;
    logic exp_req;
    logic [31:0] exp_addr;
    logic exp_valid;
    logic [31:0] exp_inst, exp_pc;
  } vec_t;
  vec_t vecs[14];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step(input logic rd, input logic rv, input logic [31:0] rdat,
                      input logic st, input logic rdv, input logic [31:0] rpc);
    @(negedge clk);
    rst = 1'b1;
    bus.imem_ready = rd;  bus.imem_rvalid = rv;  bus.imem_rdata = rdat;
    bus2.imem_ready = rd; bus2.imem_rvalid = rv; bus2.imem_rdata = rdat;
    stall = st; redirect_valid = rdv; redirect_pc = rpc;
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.imem_ready = 1'b1;  bus.imem_rvalid = 1'b1;  bus.imem_rdata = 32'hBAD0_BAD0;
    bus2.imem_ready = 1'b1; bus2.imem_rvalid = 1'b1; bus2.imem_rdata = 32'hBAD0_BAD0;
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    @(posedge clk);
    #1;
    chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, NOP);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h4);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);
  endtask
  initial begin
    vecs[0]  = '{1, 0, 32'h0,         1, 32'h0, 0, NOP,          32'h0};
    vecs[1]  = '{0, 1, 32'hA000_0000, 0, 32'h0, 0, NOP,          32'h0};
    vecs[2]  = '{1, 0, 32'h0,         0, 32'h0, 1, 32'hA000_0000, 32'h0};
    vecs[3]  = '{1, 1, 32'hDEAD_BEEF, 1, 32'h4, 0, NOP,          32'h0};
    vecs[4]  = '{0, 1, 32'hA000_0004, 0, 32'h4, 0, NOP,          32'h0};
    vecs[5]  = '{0, 0, 32'h0,         0, 32'h4, 1, 32'hA000_0004, 32'h4};
    vecs[6]  = '{1, 0, 32'h0,         1, 32'h8, 0, NOP,          32'h0};
    vecs[7]  = '{0, 1, 32'hA000_0008, 0, 32'h8, 0, NOP,          32'h0};
    vecs[8]  = '{0, 0, 32'h0,         0, 32'h8, 1, 32'hA000_0008, 32'h8};
    vecs[9]  = '{0, 0, 32'h0,         1, 32'hC, 0, NOP,          32'h0};
    vecs[10] = '{1, 0, 32'h0,         1, 32'hC, 0, NOP,          32'h0};
    vecs[11] = '{0, 0, 32'h0,         0, 32'hC, 0, NOP,          32'h0};
    vecs[12] = '{0, 1, 32'hA000_000C, 0, 32'hC, 0, NOP,          32'h0};
    vecs[13] = '{0, 0, 32'h0,         0, 32'hC, 1, 32'hA000_000C, 32'hC};
    do_reset();
    for (int i = 0; i < 14; i++) begin
      step(vecs[i].ready, vecs[i].rvalid, vecs[i].rdata, 1'b0, 1'b0, 32'h0);
      chk($sformatf("v%0d_req", i), {31'b0, bus.imem_req}, {31'b0, vecs[i].exp_req});
      chk($sformatf("v%0d_addr", i), bus.imem_addr, vecs[i].exp_addr);
      chk($sformatf("v%0d_valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].exp_valid});
      chk($sformatf("v%0d_inst", i), inst, vecs[i].exp_inst);
      if (vecs[i].exp_valid) begin
        chk($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
        chk($sformatf("v%0d_pc_plus4", i), pc_plus4, vecs[i].exp_pc + 32'd4);
      end
    end
    do_reset();
    step(1, 0, 0, 0, 0, 0);            chk("s_req0", {31'b0, bus.imem_req}, 1);
    step(0, 1, 32'hA000_0000, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);            chk("s_pc0", pc, 32'h0);
    step(1, 0, 0, 0, 0, 0);            chk("s_addr4", bus.imem_addr, 32'h4);
    step(0, 1, 32'hA000_0004, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 32'h1234_5678, 1, 0, 0);
      chk("stall_valid", {31'b0, inst_valid}, 1);
      chk("stall_inst", inst, 32'hA000_0004);
      chk("stall_pc", pc, 32'h4);
      chk("stall_req", {31'b0, bus.imem_req}, 0);
    end
    step(0, 0, 0, 0, 0, 0);            chk("stall_drop_valid", {31'b0, inst_valid}, 1);
    step(1, 0, 0, 0, 0, 0);            chk("post_stall_req", {31'b0, bus.imem_req}, 1);
                                       chk("post_stall_addr", bus.imem_addr, 32'h8);
    step(0, 0, 0, 0, 1, 32'h100);      chk("rw_req", {31'b0, bus.imem_req}, 0);
    step(0, 0, 0, 0, 0, 0);            chk("rw_addr", bus.imem_addr, 32'h100);
    step(0, 1, 32'hA000_0008, 0, 0, 0); chk("rw_valid", {31'b0, inst_valid}, 0);
    step(1, 0, 0, 0, 0, 0);            chk("rw_req2", {31'b0, bus.imem_req}, 1);
                                       chk("rw_addr2", bus.imem_addr, 32'h100);
                                       chk("rw_no_stale", inst, NOP);
    step(0, 1, 32'hA000_0100, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);            chk("rw_inst", inst, 32'hA000_0100);
                                       chk("rw_pc", pc, 32'h100);
    step(0, 0, 0, 0, 1, 32'h8);        chk("rf_addr", bus.imem_addr, 32'h104);
    step(1, 0, 0, 0, 1, 32'h200);      chk("rh_addr8", bus.imem_addr, 32'h8);
    step(0, 1, 32'hA000_0008, 0, 0, 0); chk("rh_addr", bus.imem_addr, 32'h200);
    step(1, 0, 0, 0, 0, 0);            chk("rh_req", {31'b0, bus.imem_req}, 1);
                                       chk("rh_valid", {31'b0, inst_valid}, 0);
    step(0, 1, 32'hA000_0200, 0, 0, 0);
    step(0, 0, 0, 1, 1, 32'h300);      chk("rh_inst", inst, 32'hA000_0200);
                                       chk("rh_pc_plus4", pc_plus4, 32'h204);
    step(1, 0, 0, 0, 0, 0);            chk("hold_redir_addr", bus.imem_addr, 32'h300);
                                       chk("hold_redir_inst", inst, NOP);
    step(0, 1, 32'hDEAD_BEEF, 0, 1, 32'h400);
    step(0, 0, 0, 0, 0, 0);            chk("wr_req", {31'b0, bus.imem_req}, 1);
                                       chk("wr_addr", bus.imem_addr, 32'h400);
                                       chk("wr_valid", {31'b0, inst_valid}, 0);
    step(1, 0, 0, 0, 1, 32'h102);      chk("pre_fault", {31'b0, fetch_fault}, 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 32'hA000_0000, 0, 1, 32'h500);
      chk("halt_req", {31'b0, bus.imem_req}, 0);
      chk("halt_fault", {31'b0, fetch_fault}, 1);
      chk("halt_valid", {31'b0, inst_valid}, 0);
      chk("halt_addr", bus.imem_addr, 32'h400);
    end
    do_reset();
    step(1, 0, 0, 0, 0, 0);            chk("refetch_req", {31'b0, bus.imem_req}, 1);
                                       chk("refetch_addr", bus.imem_addr, 32'h0);
                                       chk("wrap_addr0", bus2.imem_addr, 32'hFFFF_FFFC);
    step(0, 1, 32'hA000_0000, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);            chk("wrap_pc", pc2, 32'hFFFF_FFFC);
                                       chk("wrap_pc_plus4", pc_plus42, 32'h0);
    step(1, 0, 0, 0, 0, 0);            chk("wrap_req", {31'b0, bus2.imem_req}, 1);
                                       chk("wrap_addr1", bus2.imem_addr, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
